// File: rtl/csi2_test_pattern_gen_if.sv
// Parallel-video bundle between the test-pattern source and the p2b pixel-to-byte path.
// The master side is the pattern generator; the slave side is its consumer/controller.
interface csi2_test_pattern_gen_if #(
  parameter int unsigned PIX_WIDTH    = 10,
  parameter int unsigned NUM_PIX_LANE = 2
);
  logic                              enable_i;
  logic [1:0]                        mode_i;
  logic                              fv_o;
  logic                              lv_o;
  logic                              dvalid_o;
  logic [PIX_WIDTH*NUM_PIX_LANE-1:0] pixdata_o;
  logic                              frame_done_o;
  logic [15:0]                       frame_cnt_o;
  logic                              busy_o;

  modport master (
    input  enable_i, mode_i,
    output fv_o, lv_o, dvalid_o, pixdata_o, frame_done_o, frame_cnt_o, busy_o
  );

  modport slave (
    output enable_i, mode_i,
    input  fv_o, lv_o, dvalid_o, pixdata_o, frame_done_o, frame_cnt_o, busy_o
  );
endinterface

// File: rtl/csi2_test_pattern_gen.sv
// Parametrised parallel-video test-pattern source feeding the CSI-2 pixel-to-byte path.
// Produces fv/lv/dvalid/pixdata frames with configurable geometry and blanking, four
// run-time patterns, a completed-frame counter and an optional per-session frame limit.
module csi2_test_pattern_gen #(
  parameter int unsigned PIX_WIDTH    = 10,
  parameter int unsigned NUM_PIX_LANE = 2,
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned V_ACTIVE     = 720,
  parameter int unsigned H_BLANK      = 64,
  parameter int unsigned FV_SETUP     = 8,
  parameter int unsigned FV_HOLD      = 8,
  parameter int unsigned V_BLANK      = 200,
  parameter int unsigned FRAME_LIMIT  = 0
) (
  input  logic                    pix_clk_i,
  input  logic                    reset_n_i,
  csi2_test_pattern_gen_if.master vid_if
);

  localparam int unsigned HCycles = H_ACTIVE / NUM_PIX_LANE;
  // One shared cycle counter serves every state, so size it for the longest phase.
  localparam int unsigned CntW    = $clog2(HCycles + H_BLANK + FV_SETUP + FV_HOLD + V_BLANK);
  localparam int unsigned LineW   = $clog2(V_ACTIVE + 1);
  localparam int unsigned LimW    = $clog2(FRAME_LIMIT + 2);
  localparam int unsigned PixBits = PIX_WIDTH * NUM_PIX_LANE;

  typedef enum logic [2:0] {
    StIdle, StSetup, StActive, StHblank, StHold, StVblank
  } state_e;

  state_e               r_state, w_state_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d;
  logic [LineW-1:0]     r_line, w_line_d;
  logic [1:0]           r_mode, w_mode_d;
  logic [PIX_WIDTH-1:0] r_fc_val, w_fc_val_d;
  logic [15:0]          r_frame_cnt, w_frame_cnt_d;
  logic [LimW-1:0]      r_lim_cnt, w_lim_cnt_d;
  logic                 r_lim_block, w_lim_block_d;
  logic                 w_done_d;
  logic                 w_lim_hit;
  logic [PixBits-1:0]   w_pixdata_d;
  logic [31:0]          w_x;
  logic                 w_ybit;
  logic [PIX_WIDTH-1:0] w_val;

  logic                 r_fv, r_lv, r_busy, r_done;
  logic [PixBits-1:0]   r_pixdata;

  assign w_lim_hit = (FRAME_LIMIT != 0) && (r_lim_cnt == LimW'(FRAME_LIMIT));

  // Next-state logic: frame sequencing, line/cycle counting, mode latching and limits.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt + 1'b1;
    w_line_d      = r_line;
    w_mode_d      = r_mode;
    w_fc_val_d    = r_fc_val;
    w_frame_cnt_d = r_frame_cnt;
    w_lim_cnt_d   = r_lim_cnt;
    w_lim_block_d = r_lim_block;
    w_done_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (!vid_if.enable_i) begin
          // A low enable ends a limited session and re-arms the next one.
          w_lim_block_d = 1'b0;
        end else if (!r_lim_block) begin
          w_state_d   = StSetup;
          w_line_d    = '0;
          w_mode_d    = vid_if.mode_i;
          w_fc_val_d  = PIX_WIDTH'(r_frame_cnt);
          w_lim_cnt_d = '0;
        end
      end
      StSetup: begin
        if (r_cnt == CntW'(FV_SETUP - 1)) begin
          w_state_d = StActive;
          w_cnt_d   = '0;
        end
      end
      StActive: begin
        if (r_cnt == CntW'(HCycles - 1)) begin
          w_cnt_d   = '0;
          w_state_d = (r_line == LineW'(V_ACTIVE - 1)) ? StHold : StHblank;
        end
      end
      StHblank: begin
        if (r_cnt == CntW'(H_BLANK - 1)) begin
          w_state_d = StActive;
          w_cnt_d   = '0;
          w_line_d  = r_line + 1'b1;
        end
      end
      StHold: begin
        if (r_cnt == CntW'(FV_HOLD - 1)) begin
          w_state_d     = StVblank;
          w_cnt_d       = '0;
          w_done_d      = 1'b1;
          w_frame_cnt_d = r_frame_cnt + 16'd1;
          if (FRAME_LIMIT != 0) begin
            w_lim_cnt_d = r_lim_cnt + 1'b1;
          end
        end
      end
      StVblank: begin
        if (r_cnt == CntW'(V_BLANK - 1)) begin
          w_cnt_d       = '0;
          w_lim_block_d = w_lim_hit;
          if (vid_if.enable_i && !w_lim_hit) begin
            w_state_d  = StSetup;
            w_line_d   = '0;
            w_mode_d   = vid_if.mode_i;
            // r_frame_cnt already includes the frame that just finished.
            w_fc_val_d = PIX_WIDTH'(r_frame_cnt);
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Pixel generation for the upcoming cycle, so pixdata registers alongside lv.
  always_comb begin
    w_pixdata_d = '0;
    w_x         = '0;
    w_ybit      = 1'b0;
    w_val       = '0;
    if (w_state_d == StActive) begin
      for (int k = 0; k < NUM_PIX_LANE; k++) begin
        w_x    = 32'(w_cnt_d) * NUM_PIX_LANE + 32'(k);
        w_ybit = ((32'(w_line_d) >> 3) & 32'd1) != 32'd0;
        unique case (w_mode_d)
          2'd0:    w_val = PIX_WIDTH'(((w_x * 32'd8) / H_ACTIVE) << (PIX_WIDTH - 3));
          2'd1:    w_val = PIX_WIDTH'(w_x);
          2'd2:    w_val = (w_x[3] ^ w_ybit) ? '1 : '0;
          default: w_val = w_fc_val_d;
        endcase
        w_pixdata_d[k*PIX_WIDTH +: PIX_WIDTH] = w_val;
      end
    end
  end

  // State, counters and registered outputs; reset clears everything, even mid-frame.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_line      <= '0;
      r_mode      <= '0;
      r_fc_val    <= '0;
      r_frame_cnt <= '0;
      r_lim_cnt   <= '0;
      r_lim_block <= 1'b0;
      r_fv        <= 1'b0;
      r_lv        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pixdata   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_line      <= w_line_d;
      r_mode      <= w_mode_d;
      r_fc_val    <= w_fc_val_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_lim_cnt   <= w_lim_cnt_d;
      r_lim_block <= w_lim_block_d;
      r_fv        <= (w_state_d != StIdle) && (w_state_d != StVblank);
      r_lv        <= (w_state_d == StActive);
      r_busy      <= (w_state_d != StIdle);
      r_done      <= w_done_d;
      r_pixdata   <= w_pixdata_d;
    end
  end

  assign vid_if.fv_o         = r_fv;
  assign vid_if.lv_o         = r_lv;
  assign vid_if.dvalid_o     = r_lv;
  assign vid_if.pixdata_o    = r_pixdata;
  assign vid_if.frame_done_o = r_done;
  assign vid_if.frame_cnt_o  = r_frame_cnt;
  assign vid_if.busy_o       = r_busy;

endmodule

// File: tb/tb_csi2_test_pattern_gen.sv
// Directed bench for csi2_test_pattern_gen on a small frame geometry: reset/idle, frame timing,
// pattern values from a vector table, mid-frame mode/enable changes, frame limit, async reset.
module tb_csi2_test_pattern_gen;

  localparam int unsigned PW     = 10;
  localparam int unsigned NPL    = 2;
  localparam int unsigned HA     = 16;
  localparam int unsigned VA     = 4;
  localparam int unsigned HB     = 3;
  localparam int unsigned FS     = 2;
  localparam int unsigned FH     = 2;
  localparam int unsigned VB     = 5;
  localparam int unsigned HC     = HA / NPL;
  localparam int unsigned PERIOD = FS + VA * HC + (VA - 1) * HB + FH + VB;
  localparam int unsigned PXW    = PW * NPL;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csi2_test_pattern_gen_if #(.PIX_WIDTH(PW), .NUM_PIX_LANE(NPL)) if0 ();
  csi2_test_pattern_gen_if #(.PIX_WIDTH(PW), .NUM_PIX_LANE(NPL)) if1 ();

  csi2_test_pattern_gen #(
    .PIX_WIDTH(PW), .NUM_PIX_LANE(NPL), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .FV_SETUP(FS), .FV_HOLD(FH), .V_BLANK(VB), .FRAME_LIMIT(0)
  ) dut (
    .pix_clk_i(clk),
    .reset_n_i(rst_n),
    .vid_if   (if0)
  );

  csi2_test_pattern_gen #(
    .PIX_WIDTH(PW), .NUM_PIX_LANE(NPL), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .FV_SETUP(FS), .FV_HOLD(FH), .V_BLANK(VB), .FRAME_LIMIT(2)
  ) dut_lim (
    .pix_clk_i(clk),
    .reset_n_i(rst_n),
    .vid_if   (if1)
  );

  typedef struct {
    string          name;
    logic [1:0]     mode;
    int             line;
    int             cyc;
    logic [PXW-1:0] want;
  } vec_t;

  vec_t vecs[12];

  int tests = 0;
  int fails = 0;

  // Edge/timestamp monitor; only this block writes these.
  int             cyc = 0;
  int             nfv = 0, nff = 0, nlr = 0, nlf = 0, npix = 0;
  int             ndone = 0, ndone2 = 0, viol = 0;
  int             fv_rise_t[64];
  int             fv_fall_t[64];
  int             lv_rise_t[256];
  int             lv_fall_t[256];
  logic [PXW-1:0] cap[1024];
  logic           fv_q = 1'b0, lv_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.fv_o && !fv_q) begin
      if (nfv < 64) fv_rise_t[nfv] <= cyc;
      nfv <= nfv + 1;
    end
    if (!if0.fv_o && fv_q) begin
      if (nff < 64) fv_fall_t[nff] <= cyc;
      nff <= nff + 1;
    end
    if (if0.lv_o && !lv_q) begin
      if (nlr < 256) lv_rise_t[nlr] <= cyc;
      nlr <= nlr + 1;
    end
    if (!if0.lv_o && lv_q) begin
      if (nlf < 256) lv_fall_t[nlf] <= cyc;
      nlf <= nlf + 1;
    end
    if (if0.lv_o) begin
      if (npix < 1024) cap[npix] <= if0.pixdata_o;
      npix <= npix + 1;
    end
    if (if0.frame_done_o) ndone <= ndone + 1;
    if (if1.frame_done_o) ndone2 <= ndone2 + 1;
    if ((if0.frame_done_o && !(fv_q && !if0.fv_o)) ||
        (!if0.lv_o && if0.pixdata_o != '0) || (if0.dvalid_o != if0.lv_o))
      viol <= viol + 1;
    fv_q <= if0.fv_o;
    lv_q <= if0.lv_o;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  // sel 0: dut idle, 1: dut lv high, 2: dut fv rises >= target
  task automatic wait_until(input int sel, input int target, input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (sel)
        0:       ok = !if0.busy_o;
        1:       ok = if0.lv_o;
        default: ok = (nfv >= target);
      endcase
    end
    chk({"wait_", nm}, 32'(ok), 32'd1);
  endtask

  task automatic run_frame(input logic [1:0] m);
    @(posedge clk);
    #1 if0.mode_i = m;
    if0.enable_i = 1'b1;
    @(posedge clk);
    #1 if0.enable_i = 1'b0;
    wait_until(0, 0, 4 * PERIOD, "frame_idle");
  endtask

  int             bfr, bff, blr, blf, bp, bd, bd2, t_en, bad, cur_mode, exp_frames;
  logic [PXW-1:0] e;

  initial begin
    vecs[0]  = '{"ramp_l0c0",  2'd1, 0, 0, {10'd1,     10'd0}};
    vecs[1]  = '{"ramp_l0c7",  2'd1, 0, 7, {10'd15,    10'd14}};
    vecs[2]  = '{"ramp_l3c3",  2'd1, 3, 3, {10'd7,     10'd6}};
    vecs[3]  = '{"bars_l0c0",  2'd0, 0, 0, {10'h000,   10'h000}};
    vecs[4]  = '{"bars_l0c1",  2'd0, 0, 1, {10'h080,   10'h080}};
    vecs[5]  = '{"bars_l2c3",  2'd0, 2, 3, {10'h180,   10'h180}};
    vecs[6]  = '{"bars_l0c7",  2'd0, 0, 7, {10'h380,   10'h380}};
    vecs[7]  = '{"check_l0c3", 2'd2, 0, 3, {10'h000,   10'h000}};
    vecs[8]  = '{"check_l0c4", 2'd2, 0, 4, {10'h3FF,   10'h3FF}};
    vecs[9]  = '{"check_l1c5", 2'd2, 1, 5, {10'h3FF,   10'h3FF}};
    vecs[10] = '{"check_l3c0", 2'd2, 3, 0, {10'h000,   10'h000}};
    vecs[11] = '{"check_l2c7", 2'd2, 2, 7, {10'h3FF,   10'h3FF}};
    exp_frames = 0;

    // T1: reset and idle
    rst_n = 1'b0;
    if0.enable_i = 1'b0; if0.mode_i = 2'd0;
    if1.enable_i = 1'b0; if1.mode_i = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({if0.fv_o, if0.lv_o, if0.dvalid_o, if0.busy_o, if0.frame_done_o}), 0);
    chk("reset_pix", 32'(if0.pixdata_o), 0);
    chk("reset_fcnt", 32'(if0.frame_cnt_o), 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (if0.fv_o || if0.lv_o || if0.dvalid_o || if0.busy_o || if0.frame_done_o ||
          if0.pixdata_o != '0 || if0.frame_cnt_o != 16'd0) bad++;
    end
    chk("idle_100_cycles", bad, 0);

    // T2: frame timing, enable held for two frames
    bfr = nfv; bff = nff; blr = nlr; blf = nlf; bd = ndone;
    @(posedge clk);
    #1 if0.mode_i = 2'd1;
    if0.enable_i = 1'b1;
    t_en = cyc;
    wait_until(2, bfr + 2, 4 * PERIOD, "t2_second_frame");
    @(posedge clk);
    #1 if0.enable_i = 1'b0;
    wait_until(0, 0, 4 * PERIOD, "t2_idle");
    exp_frames += 2;
    chk("fv_rise_latency", fv_rise_t[bfr] - t_en, 1);
    chk("setup_len", lv_rise_t[blr] - fv_rise_t[bfr], FS);
    for (int i = 0; i < int'(VA); i++)
      chk($sformatf("lv_len_%0d", i), lv_fall_t[blf + i] - lv_rise_t[blr + i], HC);
    for (int i = 0; i < int'(VA) - 1; i++)
      chk($sformatf("hblank_%0d", i), lv_rise_t[blr + i + 1] - lv_fall_t[blf + i], HB);
    chk("hold_len", fv_fall_t[bff] - lv_fall_t[blf + VA - 1], FH);
    chk("vblank_len", fv_rise_t[bfr + 1] - fv_fall_t[bff], VB);
    chk("frame_period", fv_rise_t[bfr + 1] - fv_rise_t[bfr], PERIOD);
    chk("lv_pulses_frame0", 32'((lv_rise_t[blr + VA - 1] < fv_fall_t[bff]) &&
                                (lv_rise_t[blr + VA] > fv_fall_t[bff])), 1);
    chk("t2_done_pulses", ndone - bd, 2);
    chk("t2_frame_cnt", 32'(if0.frame_cnt_o), exp_frames);

    // T3: pattern table, one captured frame per mode
    cur_mode = -1;
    bp = 0;
    for (int i = 0; i < 12; i++) begin
      if (int'(vecs[i].mode) != cur_mode) begin
        bp = npix;
        run_frame(vecs[i].mode);
        exp_frames++;
        cur_mode = int'(vecs[i].mode);
      end
      chk(vecs[i].name, 32'(cap[bp + vecs[i].line * HC + vecs[i].cyc]), 32'(vecs[i].want));
    end

    // T4: mode change mid-frame only applies from the next frame
    bfr = nfv; bp = npix;
    @(posedge clk);
    #1 if0.mode_i = 2'd1;
    if0.enable_i = 1'b1;
    wait_until(1, 0, 4 * PERIOD, "t4_lv");
    if0.mode_i = 2'd0;
    wait_until(2, bfr + 2, 4 * PERIOD, "t4_second_frame");
    @(posedge clk);
    #1 if0.enable_i = 1'b0;
    wait_until(0, 0, 4 * PERIOD, "t4_idle");
    exp_frames += 2;
    chk("mode_held_midframe", 32'(cap[bp + 3 * HC + 7]), 32'({10'd15, 10'd14}));
    chk("mode_next_frame", 32'(cap[bp + VA * HC + 7]), 32'({10'h380, 10'h380}));

    // T4: frame-count solid pattern over two back-to-back frames
    bfr = nfv; bp = npix;
    @(posedge clk);
    #1 if0.mode_i = 2'd3;
    if0.enable_i = 1'b1;
    wait_until(2, bfr + 2, 4 * PERIOD, "t4m3_second_frame");
    @(posedge clk);
    #1 if0.enable_i = 1'b0;
    wait_until(0, 0, 4 * PERIOD, "t4m3_idle");
    e = {PW'(exp_frames), PW'(exp_frames)};
    chk("fcnt_pattern_a", 32'(cap[bp + 5]), 32'(e));
    e = {PW'(exp_frames + 1), PW'(exp_frames + 1)};
    chk("fcnt_pattern_b", 32'(cap[bp + VA * HC + 2 * HC + 1]), 32'(e));
    exp_frames += 2;
    chk("fcnt_after_m3", 32'(if0.frame_cnt_o), exp_frames);

    // T5: enable dropped mid-line still completes the frame
    bfr = nfv; bff = nff; blr = nlr; blf = nlf; bd = ndone;
    @(posedge clk);
    #1 if0.mode_i = 2'd1;
    if0.enable_i = 1'b1;
    wait_until(1, 0, 4 * PERIOD, "t5_lv");
    repeat (3) @(posedge clk);
    #1 if0.enable_i = 1'b0;
    wait_until(0, 0, 4 * PERIOD, "t5_idle");
    exp_frames++;
    chk("t5_lv_pulses", nlr - blr, VA);
    chk("t5_fv_rises", nfv - bfr, 1);
    chk("t5_done_once", ndone - bd, 1);
    chk("t5_hold_len", fv_fall_t[bff] - lv_fall_t[blf + VA - 1], FH);
    chk("t5_frame_cnt", 32'(if0.frame_cnt_o), exp_frames);

    // T5: frame limit of 2 per enable session
    bd2 = ndone2;
    @(posedge clk);
    #1 if1.enable_i = 1'b1;
    repeat (5 * PERIOD) @(posedge clk);
    #1;
    chk("limit_session1", ndone2 - bd2, 2);
    chk("limit_idle", 32'(if1.busy_o), 0);
    chk("limit_fcnt1", 32'(if1.frame_cnt_o), 2);
    if1.enable_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 if1.enable_i = 1'b1;
    repeat (5 * PERIOD) @(posedge clk);
    #1;
    chk("limit_session2", ndone2 - bd2, 4);
    chk("limit_fcnt2", 32'(if1.frame_cnt_o), 4);
    if1.enable_i = 1'b0;

    // T6: async reset mid-ACTIVE, then a clean frame
    @(posedge clk);
    #1 if0.mode_i = 2'd1;
    if0.enable_i = 1'b1;
    wait_until(1, 0, 4 * PERIOD, "t6_lv");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_ctrl", 32'({if0.fv_o, if0.lv_o, if0.dvalid_o, if0.busy_o, if0.frame_done_o}), 0);
    chk("t6_reset_pix", 32'(if0.pixdata_o), 0);
    chk("t6_reset_fcnt", 32'(if0.frame_cnt_o), 0);
    if0.enable_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_frames = 0;
    repeat (2) @(posedge clk);
    bfr = nfv; bff = nff; blr = nlr; bp = npix;
    #1 if0.enable_i = 1'b1;
    t_en = cyc;
    @(posedge clk);
    #1 if0.enable_i = 1'b0;
    wait_until(0, 0, 4 * PERIOD, "t6_idle");
    exp_frames++;
    chk("t6_fv_latency", fv_rise_t[bfr] - t_en, 1);
    chk("t6_setup_len", lv_rise_t[blr] - fv_rise_t[bfr], FS);
    chk("t6_lv_pulses", nlr - blr, VA);
    chk("t6_first_pix", 32'(cap[bp]), 32'({10'd1, 10'd0}));
    chk("t6_frame_cnt", 32'(if0.frame_cnt_o), exp_frames);

    chk("pix_zero_dvalid_done_rules", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
